ram_arbiter: RTL
================

# ram_arbiter

Two-port arbiter that shares the single unified `ram` between the CPU's instruction-fetch port and its load/store port. It picks one requester per cycle and drives the RAM address, byte enables and write strobe. It captures RAM read data into a per-port response register and inserts a turnaround cycle after every write so the bidirectional RAM data bus never has two drivers. It sits between the core's fetch/LSU stages and the top-level tri-state buffer on the RAM `data` pin.

## Interface
- `ADDR_WIDTH`, 32, address width of all ports
- `DATA_WIDTH`, 32, data width; byte-enable width is DATA_WIDTH/8 (4)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch request (read only)
- `i_addr`  in  ADDR_WIDTH  fetch address
- `i_gnt`  out  1  fetch request accepted this cycle
- `i_rvalid`  out  1  `i_rdata` valid (one cycle)
- `i_rdata`  out  DATA_WIDTH  fetch read data
- `d_req`  in  1  load/store request
- `d_wen`  in  1  1 = store, 0 = load
- `d_byte_en`  in  4  store byte lanes
- `d_addr`  in  ADDR_WIDTH  load/store address
- `d_wdata`  in  DATA_WIDTH  store data
- `d_gnt`  out  1  load/store accepted this cycle
- `d_rvalid`  out  1  `d_rdata` valid (loads only, one cycle)
- `d_rdata`  out  DATA_WIDTH  load read data
- `ram_wen`  out  1  RAM write strobe
- `ram_byte_en`  out  4  RAM byte enables
- `ram_addr`  out  ADDR_WIDTH  RAM address
- `ram_wdata`  out  DATA_WIDTH  data for the top-level tri-state driver
- `ram_data_oe`  out  1  top level drives `ram_wdata` onto RAM `data` when 1
- `ram_rdata`  in  DATA_WIDTH  RAM `data` pin as seen by the arbiter

## Operation
- FSM states: `IDLE`, `TURN`. Reset state is `IDLE`.
- `IDLE`:
  - If any request is present, grant exactly one requester. `gnt` is combinational in the same cycle.
  - `ram_addr`, `ram_wen` and `ram_byte_en` come combinationally from the granted port.
- Fetch grant:
  - `ram_wen`=0, `ram_byte_en`=4'hF.
  - `ram_rdata` is registered into `i_rdata` at the edge; `i_rvalid`=1 in the next cycle.
- Load grant:
  - `ram_wen`=0, `ram_byte_en`=4'hF (full word; the LSU extracts bytes).
  - `ram_rdata` is registered into `d_rdata`; `d_rvalid`=1 in the next cycle.
- Store grant:
  - `ram_wen`=1, `ram_byte_en`=`d_byte_en`, `ram_data_oe`=1, `ram_wdata`=`d_wdata`.
  - The RAM commits on that edge. No `d_rvalid` is produced.
  - The FSM moves to `TURN`.
- `TURN`:
  - One cycle with no grants, `ram_wen`=0 and `ram_data_oe`=0.
  - Always returns to `IDLE`.
- Requesters hold `req`, `addr`, `wen`, `byte_en` and `wdata` stable until they see `gnt`.
- A `req` deasserted before `gnt` is legal and is simply dropped.
- Arbitration with both ports requesting is set by the configuration macro (see Configuration).
- When no grant is issued:
  - `ram_wen`=0, `ram_byte_en`=0, `ram_data_oe`=0.
  - `ram_addr` holds its last value so the RAM address does not toggle.
- `i_rdata` and `d_rdata` hold their values until the next response on the same port.
- `ram_addr` is passed through at full width; the RAM masks it internally.

## Timing
- Read latency: grant at edge N, `rvalid` high for cycle N+1 only.
- Store: grant at edge N, write visible to a read granted at N+2 at the earliest (after `TURN`).
- Back-to-back reads:
  - One grant per cycle, with no bubble between them.
  - Sustained fetch-only throughput is 1 per cycle.
- Reset:
  - Asynchronous, active-low, allowed mid-operation; takes effect without waiting for a clock edge.
  - Forces `IDLE` and clears any pending `rvalid`.
  - Arbiter outputs reset to: `i_gnt`=`d_gnt`=0, `i_rvalid`=`d_rvalid`=0, `i_rdata`=`d_rdata`=0, `ram_wen`=0, `ram_byte_en`=0, `ram_data_oe`=0, `ram_addr`=0, `ram_wdata`=0. No write strobe is issued while `rst_n`=0.
  - The last-grant flag resets to "fetch", so the first contended grant goes to the data port.
- `ram_wen` and `ram_data_oe` are always asserted together.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Contention is resolved round-robin by a last-grant flop; the port not granted most recently wins.
  - The flop updates only on a contended or uncontended grant, never in `TURN`.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the data port always wins over fetch.
  - No last-grant flop is instantiated.

## Test plan
- Reset mid-access: assert `rst_n`=0 while `d_req` load is granted -> `d_rvalid` stays 0 and all `ram_*` outputs are 0 immediately after reset assertion (before the next clock edge); after release the first grant follows normal arbitration.
- Fetch stream: `i_req`=1 for addresses 0x00, 0x04, 0x08 on consecutive cycles -> `i_gnt`=1 on 3 cycles and `i_rvalid` on the next 3 cycles with the preloaded RAM words.
- Store then load: store 0xDEADBEEF with `d_byte_en`=4'b0011 to 0x10 (RAM preloaded 0x11223344) -> `ram_data_oe`=1 for one cycle, then a `TURN` cycle, then a load of 0x10 returns 0x1122BEEF.
- Contention with `ARB_ROUND_ROBIN_EN`: `i_req`=`d_req`=1 (loads) for 4 cycles -> grants alternate D, I, D, I.
- Contention without `ARB_ROUND_ROBIN_EN`: same stimulus -> D granted on all 4 cycles; I granted only once `d_req` drops.
- Turnaround: store granted while `i_req`=1 -> `i_gnt`=0 in the `TURN` cycle; fetch is granted one cycle later; there is never a cycle with `ram_data_oe`=1 and a read grant.

Source files
------------

// File: rtl/ram_arbiter.sv
// Shares one RAM between the fetch and load/store ports, with a turnaround cycle after every store.
// Optional `ARB_ROUND_ROBIN_EN`: round-robin on contention instead of data-port priority.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic                    i_gnt,
   output logic                    i_rvalid,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   input  logic                    d_req,
   input  logic                    d_wen,
   input  logic [DATA_WIDTH/8-1:0] d_byte_en,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    ram_wen,
   output logic [DATA_WIDTH/8-1:0] ram_byte_en,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_wdata,
   output logic                    ram_data_oe,
   input  logic [DATA_WIDTH-1:0]   ram_rdata
);

   typedef enum logic {IDLE, TURN} state_t;

   state_t                  state_q, state_d;
   logic                    i_gnt_c, d_gnt_c, store_c, d_wins;
   logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
   logic                    i_rvalid_q, d_rvalid_q;
   logic [DATA_WIDTH-1:0]   i_rdata_q, d_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 when the data port received the most recent grant.
   logic last_d_q, last_d_d;

   always_comb begin
      last_d_d = last_d_q;
      if (d_gnt_c)      last_d_d = 1'b1;
      else if (i_gnt_c) last_d_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_d_q <= 1'b0;
      else        last_d_q <= last_d_d;
   end

   assign d_wins = !last_d_q;
`else
   assign d_wins = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      i_gnt_c = 1'b0;
      d_gnt_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (d_req && (!i_req || d_wins)) d_gnt_c = 1'b1;
            else if (i_req)                  i_gnt_c = 1'b1;
            if (d_gnt_c && d_wen)            state_d = TURN;
         end
         TURN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Grants are combinational, so they must also vanish while reset is held.
      if (!rst_n) begin
         i_gnt_c = 1'b0;
         d_gnt_c = 1'b0;
      end
   end

   assign store_c = d_gnt_c && d_wen;

   always_comb begin
      ram_addr_d = ram_addr_q;
      if (d_gnt_c)      ram_addr_d = d_addr;
      else if (i_gnt_c) ram_addr_d = i_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ram_addr_q <= '0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         ram_addr_q <= ram_addr_d;
         i_rvalid_q <= i_gnt_c;
         d_rvalid_q <= d_gnt_c && !d_wen;
         if (i_gnt_c)            i_rdata_q <= ram_rdata;
         if (d_gnt_c && !d_wen)  d_rdata_q <= ram_rdata;
      end
   end

   assign i_gnt       = i_gnt_c;
   assign d_gnt       = d_gnt_c;
   assign i_rvalid    = i_rvalid_q;
   assign d_rvalid    = d_rvalid_q;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign ram_wen     = store_c;
   assign ram_data_oe = store_c;
   assign ram_wdata   = store_c ? d_wdata : '0;
   assign ram_addr    = ram_addr_d;
   assign ram_byte_en = store_c ? d_byte_en :
                        (i_gnt_c || d_gnt_c) ? {(DATA_WIDTH/8){1'b1}} : '0;

endmodule
